// File: rtl/fft_ramwriter.sv
// fft_ramwriter: packs one channel's FFT output frame into the bin RAM.
// Ports: Avalon-ST src_* in, rd_done release in; RAM wren/wraddress/data out,
//        fftdone pulse, busy, sticky overrun/frame_err status out.
module fft_ramwriter #(
    parameter int NPOINT = 1024,
    parameter int AW     = 10,
    parameter int DW     = 14
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            src_valid,
    input  logic            src_sop,
    input  logic            src_eop,
    input  logic [DW-1:0]   src_real,
    input  logic [DW-1:0]   src_imag,
    input  logic [1:0]      src_error,
    input  logic            rd_done,
    output logic            wren,
    output logic [AW-1:0]   wraddress,
    output logic [2*DW-1:0] data,
    output logic            fftdone,
    output logic            busy,
    output logic            overrun,
    output logic            frame_err
);

    typedef enum logic [1:0] {IDLE, WRITE, HOLD, DROP} state_t;

    localparam logic [AW-1:0] LAST = AW'(NPOINT - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            wren_q, wren_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2*DW-1:0] data_q, data_d;
    logic            pend_q, pend_d;
    logic            done_q;
    logic            ovr_q, ovr_d;
    logic            ferr_q, ferr_d;
    logic            held_q, held_d;

    logic            take;
    logic [AW-1:0]   bin;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wren_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        pend_d  = 1'b0;
        ovr_d   = ovr_q;
        ferr_d  = ferr_q;
        held_d  = held_q;
        take    = 1'b0;
        bin     = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (src_valid && src_sop) begin
                    take = 1'b1;
                    bin  = '0;
                end
            end
            WRITE: begin
                if (src_valid) begin
                    take = 1'b1;
                    if (src_sop) begin
                        ferr_d = 1'b1;
                        bin    = '0;
                    end
                end
            end
            HOLD: begin
                if (rd_done) begin
                    held_d  = 1'b0;
                    state_d = IDLE;
                end
                if (src_valid && src_sop) begin
                    if (rd_done) begin
                        take = 1'b1;
                        bin  = '0;
                    end else begin
                        // RAM still owned by readers: discard this frame.
                        ovr_d   = 1'b1;
                        state_d = src_eop ? HOLD : DROP;
                    end
                end
            end
            DROP: begin
                if (rd_done) held_d = 1'b0;
                if (src_valid && src_eop)
                    state_d = (held_q && !rd_done) ? HOLD : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            if (src_error != 2'd0) begin
                // An errored sample that also ends the frame has nothing
                // left to drop.
                ferr_d  = 1'b1;
                state_d = src_eop ? IDLE : DROP;
            end else begin
                wren_d = 1'b1;
                addr_d = bin;
                data_d = {src_real, src_imag};
                if (src_eop && bin == LAST) begin
                    state_d = HOLD;
                    held_d  = 1'b1;
                    pend_d  = 1'b1;
                end else if (src_eop || bin == LAST) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = bin + AW'(1);
                    state_d = WRITE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            // fftdone trails the final RAM write by one cycle.
            pend_q  <= pend_d;
            done_q  <= pend_q;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            held_q  <= held_d;
        end
    end

    assign wren      = wren_q;
    assign wraddress = addr_q;
    assign data      = data_q;
    assign fftdone   = done_q;
    assign busy      = (state_q == WRITE) || (state_q == HOLD);
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_fft_ramwriter.sv
// tb_fft_ramwriter: frame-level reference model for fft_ramwriter.
// Drives whole frames and checks RAM writes, fftdone and status flags.
module tb_fft_ramwriter;

    localparam int NPOINT = 1024;
    localparam int AW     = 10;
    localparam int DW     = 14;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            src_valid = 1'b0;
    logic            src_sop = 1'b0;
    logic            src_eop = 1'b0;
    logic [DW-1:0]   src_real = '0;
    logic [DW-1:0]   src_imag = '0;
    logic [1:0]      src_error = '0;
    logic            rd_done = 1'b0;
    logic            wren;
    logic [AW-1:0]   wraddress;
    logic [2*DW-1:0] data;
    logic            fftdone;
    logic            busy;
    logic            overrun;
    logic            frame_err;

    fft_ramwriter #(.NPOINT(NPOINT), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_real(src_real), .src_imag(src_imag), .src_error(src_error),
        .rd_done(rd_done),
        .wren(wren), .wraddress(wraddress), .data(data),
        .fftdone(fftdone), .busy(busy),
        .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int act_a[$];
    int act_d[$];
    int act_c[$];
    int done_c[$];
    int exp_a[$];
    int exp_d[$];

    bit model_held = 0;
    bit exp_ovr    = 0;
    bit exp_ferr   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wren) begin
            act_a.push_back(int'(wraddress));
            act_d.push_back(int'(data));
            act_c.push_back(cyc);
        end
        if (fftdone) done_c.push_back(cyc);
    end

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wren"}, int'(wren), 0);
        check({tag, "_addr"}, int'(wraddress), 0);
        check({tag, "_data"}, int'(data), 0);
        check({tag, "_done"}, int'(fftdone), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_ovr"}, int'(overrun), 0);
        check({tag, "_ferr"}, int'(frame_err), 0);
    endtask

    task automatic pulse_rd_done();
        @(posedge clk); #1;
        rd_done = 1'b1;
        @(posedge clk); #1;
        rd_done = 1'b0;
        model_held = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    // last: eop bin; err: errored bin or -1; abort: reset bin or -1
    task automatic send_frame(input string tag, input int last, input int err,
                              input int abort, input bit gaps,
                              input bit ramp, input bit rd_with_sop);
        logic [DW-1:0] r, im;
        int  nw, bad, nexp;
        bit  good, accepted;
        act_a.delete(); act_d.delete(); act_c.delete(); done_c.delete();
        exp_a.delete(); exp_d.delete();
        if (rd_with_sop) model_held = 0;
        accepted = !model_held;
        nw = 0;
        if (accepted) begin
            nw = last + 1;
            if (err >= 0 && err < nw) nw = err;
            if (abort >= 0 && abort < nw) nw = abort;
        end
        good = accepted && last == NPOINT - 1 && err < 0 && abort < 0;
        for (int k = 0; k <= last; k++) begin
            if (gaps && k > 0) begin
                while ($urandom_range(1, 0) == 1) begin
                    @(posedge clk); #1;
                    src_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
            rd_done = (rd_with_sop && k == 0);
            if (k == abort) begin
                src_valid = 1'b0;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                check_zero({tag, "_rst"});
                break;
            end
            if (ramp) begin
                r  = DW'(k);
                im = DW'(-k);
            end else begin
                r  = DW'($urandom);
                im = DW'($urandom);
            end
            src_valid = 1'b1;
            src_sop   = (k == 0);
            src_eop   = (k == last);
            src_real  = r;
            src_imag  = im;
            src_error = (k == err) ? 2'd2 : 2'd0;
            if (k < nw) begin
                exp_a.push_back(k);
                exp_d.push_back(int'({r, im}));
            end
        end
        @(posedge clk); #1;
        src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0;
        src_error = 2'd0; rd_done = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);

        if (abort >= 0) begin
            model_held = 0; exp_ovr = 0; exp_ferr = 0;
        end else begin
            if (!accepted) exp_ovr = 1;
            else if (!good) exp_ferr = 1;
            if (good) model_held = 1;
        end

        check({tag, "_nwr"}, act_a.size(), exp_a.size());
        bad = 0;
        for (int i = 0; i < act_a.size() && i < exp_a.size(); i++)
            if (act_a[i] != exp_a[i] || act_d[i] != exp_d[i]) bad++;
        check({tag, "_wrbad"}, bad, 0);
        nexp = good ? 1 : 0;
        check({tag, "_ndone"}, done_c.size(), nexp);
        if (good && done_c.size() > 0 && act_c.size() > 0)
            check({tag, "_donelat"}, done_c[0] - act_c[act_c.size()-1], 1);
        check({tag, "_ovr"}, int'(overrun), int'(exp_ovr));
        check({tag, "_ferr"}, int'(frame_err), int'(exp_ferr));
        check({tag, "_busy"}, int'(busy), int'(model_held));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        send_frame("full", NPOINT-1, -1, -1, 0, 1, 0);
        pulse_rd_done();
        check("rel1_busy", int'(busy), 0);

        send_frame("gap", NPOINT-1, -1, -1, 1, 0, 0);
        pulse_rd_done();

        send_frame("short", 500, -1, -1, 0, 0, 0);
        send_frame("good", NPOINT-1, -1, -1, 1, 0, 0);
        send_frame("held", NPOINT-1, -1, -1, 0, 0, 0);
        pulse_rd_done();
        check("rel2_busy", int'(busy), 0);
        send_frame("third", NPOINT-1, -1, -1, 0, 0, 0);
        send_frame("b2b", NPOINT-1, -1, -1, 0, 0, 1);
        pulse_rd_done();

        send_frame("rstmid", NPOINT-1, -1, 300, 0, 0, 0);
        send_frame("fresh", NPOINT-1, -1, -1, 0, 0, 0);
        pulse_rd_done();

        send_frame("err", NPOINT-1, 10, -1, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
